// File: rtl/axi_lite_core_ctrl.sv
// -----------------------------------------------------------------------------
// axi_lite_core_ctrl
//
// AXI4-Lite slave register block for the four-core design. It decodes bus
// accesses into four per-core argument registers, a start-pulse register and
// a sticky done-status register.
//
// Register map (byte address, bits [1:0] ignored):
//   0x00-0x0C  ARG0..ARG3  RW, byte-strobed
//   0x10       CTRL        write bit i = 1 pulses core_start[i]; reads 0
//   0x14       STATUS      [3:0] sticky done, write-1-to-clear; [31:4] read 0
//   0x18-0x1C  unmapped    writes ignored, reads 0, response SLVERR
//
// Ports:
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   S_AXI_AW* / S_AXI_W*   write address / data channels
//   S_AXI_B*               write response channel
//   S_AXI_AR* / S_AXI_R*   read address / data channels
//   core_arg               {ARG3,ARG2,ARG1,ARG0}, core i uses [32i+31:32i]
//   core_start             one-cycle start pulse per core
//   core_done              per-core done pulse, synchronous to ACLK
//
// Handshake semantics: a transfer happens on a rising ACLK edge where both
// VALID and READY of a channel are high. A VALID, once raised, holds its
// payload stable until that edge. READY outputs here are registered and are
// high for exactly one cycle per accepted transaction. The write path only
// accepts AW and W together (both valids high); the read and write paths are
// independent of each other.
// -----------------------------------------------------------------------------
module axi_lite_core_ctrl #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_CORES          = 4
) (
    input  logic                                ACLK,
    input  logic                                ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
    input  logic [2:0]                          S_AXI_AWPROT,
    input  logic                                S_AXI_AWVALID,
    output logic                                S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
    input  logic                                S_AXI_WVALID,
    output logic                                S_AXI_WREADY,
    output logic [1:0]                          S_AXI_BRESP,
    output logic                                S_AXI_BVALID,
    input  logic                                S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
    input  logic [2:0]                          S_AXI_ARPROT,
    input  logic                                S_AXI_ARVALID,
    output logic                                S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
    output logic [1:0]                          S_AXI_RRESP,
    output logic                                S_AXI_RVALID,
    input  logic                                S_AXI_RREADY,
    output logic [NUM_CORES*C_S_AXI_DATA_WIDTH-1:0] core_arg,
    output logic [NUM_CORES-1:0]                core_start,
    input  logic [NUM_CORES-1:0]                core_done
);

    localparam int          NBYTES      = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [2:0]  IDX_CTRL    = 3'd4;
    localparam logic [2:0]  IDX_STATUS  = 3'd5;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    // Both FSM states gathered in one place so checkers can bind to them.
    typedef struct packed {
        w_state_t wr;
        r_state_t rd;
    } fsm_dbg_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    w_state_t                        r_wstate;
    r_state_t                        r_rstate;
    logic                            r_awready;   // drives both AWREADY and WREADY
    logic                            r_bvalid;
    logic [1:0]                      r_bresp;
    logic                            r_arready;
    logic                            r_rvalid;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]                      r_rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_arg [NUM_CORES];
    logic [NUM_CORES-1:0]            r_status;
    logic [NUM_CORES-1:0]            r_core_start;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    w_state_t                        w_wstate_nxt;
    r_state_t                        w_rstate_nxt;
    logic                            w_awready_nxt;
    logic                            w_bvalid_nxt;
    logic [1:0]                      w_bresp_nxt;
    logic                            w_wr_en;     // write handshake on this edge
    logic                            w_arready_nxt;
    logic                            w_rvalid_nxt;
    logic                            w_rd_en;     // read handshake on this edge
    logic [2:0]                      w_aw_idx;
    logic [2:0]                      w_ar_idx;
    logic                            w_aw_is_arg;
    logic                            w_aw_unmapped;
    logic [C_S_AXI_DATA_WIDTH-1:0]   w_rd_data;
    logic [1:0]                      w_rd_resp;
    logic [NUM_CORES-1:0]            w_status_clr;
    logic [NUM_CORES-1:0]            w_start_nxt;
    fsm_dbg_t                        w_dbg_fsm;
    logic                            w_unused_sink;

    assign w_aw_idx      = S_AXI_AWADDR[4:2];
    assign w_ar_idx      = S_AXI_ARADDR[4:2];
    assign w_aw_is_arg   = (w_aw_idx[2] == 1'b0);
    assign w_aw_unmapped = w_aw_idx[2] & w_aw_idx[1];

    assign w_dbg_fsm.wr  = r_wstate;
    assign w_dbg_fsm.rd  = r_rstate;

    // Inputs the register map never looks at, plus the debug view.
    assign w_unused_sink = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                             S_AXI_ARADDR[1:0], w_dbg_fsm};

    // -------------------------------------------------------------------------
    // Write FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= w_awready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_awready_nxt = 1'b0;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        w_wr_en       = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (r_awready) begin
                    // READY is up this cycle: the next edge is the handshake.
                    if (S_AXI_AWVALID && S_AXI_WVALID) begin
                        w_wr_en      = 1'b1;
                        w_bvalid_nxt = 1'b1;
                        w_bresp_nxt  = w_aw_unmapped ? RESP_SLVERR : RESP_OKAY;
                        w_wstate_nxt = W_RESP;
                    end
                end else if (S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid) begin
                    w_awready_nxt = 1'b1;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_bvalid_nxt = 1'b0;
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Read FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_arready_nxt = 1'b0;
        w_rvalid_nxt  = r_rvalid;
        w_rd_en       = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (r_arready) begin
                    if (S_AXI_ARVALID) begin
                        w_rd_en      = 1'b1;
                        w_rvalid_nxt = 1'b1;
                        w_rstate_nxt = R_DATA;
                    end
                end else if (S_AXI_ARVALID) begin
                    w_arready_nxt = 1'b1;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    w_rvalid_nxt = 1'b0;
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read mux works from current register contents, so a read that shares
    // its handshake edge with a write sees the value before that write.
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (w_ar_idx)
            3'd0, 3'd1, 3'd2, 3'd3: w_rd_data = r_arg[w_ar_idx[1:0]];
            IDX_STATUS: w_rd_data = {{(C_S_AXI_DATA_WIDTH-NUM_CORES){1'b0}}, r_status};
            IDX_CTRL:   w_rd_data = '0;
            default:    w_rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_rd_en) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_resp;
        end
    end

    // -------------------------------------------------------------------------
    // Argument registers
    // -------------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                r_arg[i] <= '0;
            end
        end else if (w_wr_en && w_aw_is_arg) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    r_arg[w_aw_idx[1:0]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Start pulses and sticky done status
    // -------------------------------------------------------------------------
    // Only byte 0 carries CTRL/STATUS bits, so WSTRB[0] gates them.
    assign w_start_nxt  = (w_wr_en && (w_aw_idx == IDX_CTRL))
                          ? (S_AXI_WDATA[NUM_CORES-1:0] & {NUM_CORES{S_AXI_WSTRB[0]}})
                          : '0;
    assign w_status_clr = (w_wr_en && (w_aw_idx == IDX_STATUS) && S_AXI_WSTRB[0])
                          ? S_AXI_WDATA[NUM_CORES-1:0]
                          : '0;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_core_start <= '0;
            r_status     <= '0;
        end else begin
            r_core_start <= w_start_nxt;
            // A done pulse arriving with a clear keeps the bit set.
            r_status     <= (r_status & ~w_status_clr) | core_done;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_awready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign core_start    = r_core_start;

    genvar g;
    generate
        for (g = 0; g < NUM_CORES; g++) begin : g_arg
            assign core_arg[C_S_AXI_DATA_WIDTH*g +: C_S_AXI_DATA_WIDTH] = r_arg[g];
        end
    endgenerate

endmodule

// File: tb/tb_axi_lite_core_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for axi_lite_core_ctrl.
// Inputs are driven 1 time unit after a rising edge; everything is sampled on
// the falling edge. A bench-side register-map model predicts every output each
// cycle; directed transactions are also checked against hand-computed values.
// -----------------------------------------------------------------------------
module tb_axi_lite_core_ctrl;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic ACLK = 1'b0;
  logic ARESETN;
  always #5 ACLK = ~ACLK;

  logic [4:0]   S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [4:0]   S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [127:0] core_arg;
  logic [3:0]   core_start;
  logic [3:0]   core_done;

  axi_lite_core_ctrl dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .core_arg      (core_arg),
    .core_start    (core_start),
    .core_done     (core_done)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / model state
  // ---------------------------------------------------------------------------
  int          errors = 0;
  int          checks = 0;
  int          start_cnt = 0;
  logic [3:0]  start_val = 4'h0;

  logic [31:0] m_arg [4];
  logic [3:0]  m_status;
  logic [3:0]  m_start;
  logic        m_awready;
  logic        m_bvalid;
  logic [1:0]  m_bresp;
  logic        m_arready;
  logic        m_rvalid;
  logic [33:0] exp_q[$];   // {RRESP, RDATA} of accepted reads

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] model_read(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: return {2'b00, m_arg[idx[1:0]]};
      3'd4:                   return 34'd0;
      3'd5:                   return {2'b00, 28'd0, m_status};
      default:                return {2'b10, 32'd0};
    endcase
  endfunction

  // One falling-edge step: compare outputs, then advance the model to what the
  // next rising edge must produce given the inputs now on the bus.
  task automatic model_step();
    logic [2:0] idx;
    logic [3:0] clr;
    logic [3:0] nxt_start;
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) m_arg[i] = 32'd0;
      m_status = 4'd0; m_start = 4'd0;
      m_awready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
      m_arready = 1'b0; m_rvalid = 1'b0;
      exp_q.delete();
    end
    chk("awready", S_AXI_AWREADY, m_awready);
    chk("wready", S_AXI_WREADY, m_awready);
    chk("bvalid", S_AXI_BVALID, m_bvalid);
    if (m_bvalid) chk("bresp", S_AXI_BRESP, m_bresp);
    chk("arready", S_AXI_ARREADY, m_arready);
    chk("rvalid", S_AXI_RVALID, m_rvalid);
    if (m_rvalid && exp_q.size() > 0) chk("rdata_rresp", {S_AXI_RRESP, S_AXI_RDATA}, exp_q[0]);
    chk("core_arg", core_arg, {m_arg[3], m_arg[2], m_arg[1], m_arg[0]});
    chk("core_start", core_start, m_start);
    if (core_start != 4'd0) begin
      start_cnt++;
      start_val = core_start;
    end
    if (!ARESETN) return;

    // read side uses register values from before any write on the same edge
    if (m_arready && S_AXI_ARVALID) begin
      exp_q.push_back(model_read(S_AXI_ARADDR[4:2]));
      m_rvalid  = 1'b1;
      m_arready = 1'b0;
    end else if (m_rvalid && S_AXI_RREADY) begin
      void'(exp_q.pop_front());
      m_rvalid  = 1'b0;
      m_arready = 1'b0;
    end else begin
      m_arready = !m_arready && !m_rvalid && S_AXI_ARVALID;
    end

    clr = 4'd0;
    nxt_start = 4'd0;
    if (m_awready && S_AXI_AWVALID && S_AXI_WVALID) begin
      idx = S_AXI_AWADDR[4:2];
      if (idx < 3'd4) begin
        for (int b = 0; b < 4; b++)
          if (S_AXI_WSTRB[b]) m_arg[idx[1:0]][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
      end
      if (idx == 3'd4) nxt_start = S_AXI_WDATA[3:0] & {4{S_AXI_WSTRB[0]}};
      if (idx == 3'd5 && S_AXI_WSTRB[0]) clr = S_AXI_WDATA[3:0];
      m_bresp   = (idx >= 3'd6) ? 2'b10 : 2'b00;
      m_bvalid  = 1'b1;
      m_awready = 1'b0;
    end else if (m_bvalid && S_AXI_BREADY) begin
      m_bvalid  = 1'b0;
      m_awready = 1'b0;
    end else begin
      m_awready = !m_awready && !m_bvalid && S_AXI_AWVALID && S_AXI_WVALID;
    end
    m_status = (m_status & ~clr) | core_done;
    m_start  = nxt_start;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // which: 0 AWREADY, 1 BVALID, 2 ARREADY, 3 RVALID. Returns at the falling
  // edge where the signal is seen high, so the next rising edge is the transfer.
  task automatic wait_for(input int which, input string name);
    logic seen;
    for (int n = 0; n < 40; n++) begin
      @(negedge ACLK);
      case (which)
        0:       seen = S_AXI_AWREADY;
        1:       seen = S_AXI_BVALID;
        2:       seen = S_AXI_ARREADY;
        default: seen = S_AXI_RVALID;
      endcase
      if (seen) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout_%s: got no handshake expected one within 40 cycles", name);
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_lead, input int bready_wait, input logic [3:0] done_mask,
                          output logic [1:0] resp);
    @(posedge ACLK); #1;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1;
    repeat (aw_lead) begin @(posedge ACLK); #1; end
    S_AXI_WVALID = 1'b1;
    // READY comes up one edge after both valids; a done pulse placed here
    // lands on the handshake edge.
    @(posedge ACLK); #1;
    core_done = done_mask;
    wait_for(0, "awready");
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; core_done = 4'd0;
    repeat (bready_wait) begin @(posedge ACLK); #1; end
    S_AXI_BREADY = 1'b1;
    wait_for(1, "bvalid");
    resp = S_AXI_BRESP;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    @(posedge ACLK); #1;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    wait_for(2, "arready");
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    wait_for(3, "rvalid");
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence with literal expectations
  // ---------------------------------------------------------------------------
  task automatic main_seq();
    logic [31:0] d;
    logic [1:0]  r;
    int          s0;

    repeat (3) @(posedge ACLK);
    #1;
    chk("reset_outputs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY,
                          S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA, core_start}, 128'd0);
    chk("reset_core_arg", core_arg, 128'd0);
    ARESETN = 1'b1;

    for (int i = 0; i < 4; i++) begin
      do_write(5'(i * 4), 32'(i + 1), 4'hF, 0, 0, 4'd0, r);
      chk("arg_bresp", r, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      do_read(5'(i * 4), d, r);
      chk("arg_readback", {r, d}, {2'b00, 32'(i + 1)});
    end
    chk("core_arg_map", core_arg, 128'h00000004_00000003_00000002_00000001);

    do_write(5'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 4'd0, r);
    do_read(5'h04, d, r);
    chk("wstrb_merge", d, 32'h00BB00DD);

    s0 = start_cnt;
    do_write(5'h10, 32'h5, 4'hF, 0, 0, 4'd0, r);
    chk("start_pulse_cycles", start_cnt - s0, 1);
    chk("start_pulse_value", start_val, 4'b0101);
    do_read(5'h10, d, r);
    chk("ctrl_reads_zero", {r, d}, 34'd0);

    @(posedge ACLK); #1; core_done = 4'b0100;
    @(posedge ACLK); #1; core_done = 4'b0000;
    do_read(5'h14, d, r);
    chk("status_sticky", d, 32'h4);
    do_write(5'h14, 32'h4, 4'hF, 0, 0, 4'b0100, r);
    do_read(5'h14, d, r);
    chk("status_set_wins", d, 32'h4);
    do_write(5'h14, 32'h4, 4'hF, 0, 0, 4'd0, r);
    do_read(5'h14, d, r);
    chk("status_w1c", d, 32'h0);

    // AW ahead of W, BREADY held off, and a second write queued behind it.
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 5'h08; S_AXI_WDATA = 32'h33; S_AXI_WSTRB = 4'hF; S_AXI_AWVALID = 1'b1;
    repeat (3) begin @(posedge ACLK); #1; end
    S_AXI_WVALID = 1'b1;
    wait_for(0, "awready_lead");
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'h44;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      chk("bvalid_hold", {S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY}, 4'b1000);
    end
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b1;
    wait_for(1, "bvalid_first");
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    wait_for(0, "awready_second");
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    wait_for(1, "bvalid_second");
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    do_read(5'h08, d, r);
    chk("lead_write_arg2", d, 32'h33);
    do_read(5'h0C, d, r);
    chk("queued_write_arg3", d, 32'h44);

    do_read(5'h18, d, r);
    chk("unmapped_read", {r, d}, {2'b10, 32'd0});
    do_write(5'h1C, 32'hFFFFFFFF, 4'hF, 0, 0, 4'd0, r);
    chk("unmapped_bresp", r, 2'b10);
    chk("unmapped_no_change", core_arg, 128'h00000044_00000033_00BB00DD_00000001);

    // Reset in the middle of a pending read response.
    @(posedge ACLK); #1;
    S_AXI_ARADDR = 5'h00; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    wait_for(2, "arready_rst");
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    wait_for(3, "rvalid_rst");
    #2;
    ARESETN = 1'b0;
    #1;
    chk("async_reset_outputs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP, S_AXI_ARREADY,
                                S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA, core_start}, 128'd0);
    chk("async_reset_core_arg", core_arg, 128'd0);
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    do_read(5'h00, d, r);
    chk("post_reset_arg0", {r, d}, 34'd0);
    do_read(5'h14, d, r);
    chk("post_reset_status", {r, d}, 34'd0);
    repeat (3) @(posedge ACLK);
  endtask

  initial begin
    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    core_done = '0;
    fork
      begin
        forever begin
          @(negedge ACLK);
          model_step();
        end
      end
      begin
        main_seq();
      end
      begin
        #200000;
        checks++;
        errors++;
        $display("FAIL global_timeout: got no end of sequence expected it within 200000 time units");
      end
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
